// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the CPU data-port responder: word width,
// MMIO register offsets, the region decode and the request bundle.
package mips_mem_pkg;

  localparam int WORD_W = 32;

  localparam logic [3:0] OFF_LED = 4'h0;
  localparam logic [3:0] OFF_CNT = 4'h4;
  localparam logic [3:0] OFF_ERR = 4'h8;

  typedef enum logic [1:0] {
    REG_RAM  = 2'd0,
    REG_MMIO = 2'd1,
    REG_BAD  = 2'd2
  } region_e;

  typedef struct packed {
    logic              ena;
    logic              wea;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
  } mem_req_t;

  // Alignment is checked first so a misaligned hit on the ERR register is
  // an error rather than a clear.
  function automatic region_e decode_region(input logic [WORD_W-1:0] a,
                                            input logic [WORD_W-1:0] ram_bytes,
                                            input logic [WORD_W-1:0] base);
    if (a[1:0] != 2'b00)                           return REG_BAD;
    else if (a < ram_bytes)                        return REG_RAM;
    else if (a >= base && (a - base) < 32'd16)     return REG_MMIO;
    else                                           return REG_BAD;
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// CPU data-port bundle: request fields driven by the CPU, registered read
// data returned by the responder.
interface data_mem_responder_if;
  import mips_mem_pkg::*;

  logic              data_ram_ena;
  logic              data_ram_wea;
  logic [WORD_W-1:0] addr;
  logic [WORD_W-1:0] wdata;
  logic [WORD_W-1:0] rdata;

  modport master (output data_ram_ena, data_ram_wea, addr, wdata,
                  input  rdata);
  modport slave  (input  data_ram_ena, data_ram_wea, addr, wdata,
                  output rdata);
endinterface

// File: rtl/data_mem_responder_ram.sv
// Single-port synchronous word RAM with one-cycle registered read. The
// output register only loads on reads, so it holds across writes and idles.
module dmem_ram_1p
  import mips_mem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     idx,
  input  logic [WORD_W-1:0] din,
  output logic [WORD_W-1:0] dout
);

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [WORD_W-1:0] r_dout;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) r_mem[idx] <= din;
      else    r_dout     <= r_mem[idx];
    end
  end

  assign dout = r_dout;

endmodule

// File: rtl/data_mem_responder.sv
// Data-port responder: decodes each CPU access to RAM, MMIO or error and
// returns read data one cycle later. Hosts LED, cycle counter and error regs.
module data_mem_responder
  import mips_mem_pkg::*;
#(
  parameter int                DEPTH_WORDS = 1024,
  parameter logic [WORD_W-1:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  data_mem_responder_if.slave  bus,
  output logic [15:0]          led,
  output logic                 err,
  output logic [WORD_W-1:0]    err_addr
);

  localparam int                AW        = $clog2(DEPTH_WORDS);
  localparam logic [WORD_W-1:0] RAM_BYTES = WORD_W'(DEPTH_WORDS * 4);

  mem_req_t          w_req;
  region_e           w_region;
  logic [3:0]        w_off;
  logic              w_ram_en;
  logic [WORD_W-1:0] w_ram_dout;
  logic [WORD_W-1:0] w_mmio_rd;

  logic [15:0]       r_led;
  logic              r_err;
  logic [WORD_W-1:0] r_err_addr;
  logic [WORD_W-1:0] r_cnt;
  logic [WORD_W-1:0] r_rd;
  logic              r_src_ram;

  assign w_req    = '{ena:   bus.data_ram_ena, wea:   bus.data_ram_wea,
                      addr:  bus.addr,         wdata: bus.wdata};
  assign w_region = decode_region(w_req.addr, RAM_BYTES, MMIO_BASE);
  assign w_off    = w_req.addr[3:0];

  // Gating with rst drops a write that coincides with reset.
  assign w_ram_en = !rst && w_req.ena && (w_region == REG_RAM);

  dmem_ram_1p #(.DEPTH(DEPTH_WORDS), .AW(AW)) u_ram (
    .clk  (clk),
    .en   (w_ram_en),
    .we   (w_req.wea),
    .idx  (w_req.addr[AW+1:2]),
    .din  (w_req.wdata),
    .dout (w_ram_dout)
  );

  always_comb begin
    w_mmio_rd = '0;
    case (w_off)
      OFF_LED: w_mmio_rd = {16'b0, r_led};
      OFF_CNT: w_mmio_rd = r_cnt;
      OFF_ERR: w_mmio_rd = {{(WORD_W-1){1'b0}}, r_err};
      default: w_mmio_rd = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_led      <= '0;
      r_err      <= 1'b0;
      r_err_addr <= '0;
      r_cnt      <= '0;
      r_rd       <= '0;
      r_src_ram  <= 1'b0;
    end else begin
      r_cnt <= r_cnt + 32'd1;
      if (w_req.ena) begin
        unique case (w_region)
          REG_RAM: begin
            if (!w_req.wea) r_src_ram <= 1'b1;
          end
          REG_MMIO: begin
            if (w_req.wea) begin
              if (w_off == OFF_LED) r_led <= w_req.wdata[15:0];
              if (w_off == OFF_ERR) begin
                r_err      <= 1'b0;
                r_err_addr <= '0;
              end
            end else begin
              r_src_ram <= 1'b0;
              r_rd      <= w_mmio_rd;
            end
          end
          default: begin
            r_err <= 1'b1;
            if (!r_err) r_err_addr <= w_req.addr;
            if (!w_req.wea) begin
              r_src_ram <= 1'b0;
              r_rd      <= '0;
            end
          end
        endcase
      end
    end
  end

  // r_src_ram records which source the last completed read came from.
  assign bus.rdata = r_src_ram ? w_ram_dout : r_rd;
  assign led       = r_led;
  assign err       = r_err;
  assign err_addr  = r_err_addr;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: an address-map model plus literal
// expectations, checked against the DUT on every negative clock edge.
module tb_data_mem_responder;
  import mips_mem_pkg::*;

  localparam int          DW   = 1024;
  localparam logic [31:0] MB   = 32'hFFFF_0000;
  localparam logic [31:0] RAMB = 32'(DW * 4);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] led;
  logic        err;
  logic [31:0] err_addr;

  data_mem_responder_if bus();

  data_mem_responder #(.DEPTH_WORDS(DW), .MMIO_BASE(MB)) dut (
    .clk(clk), .rst(rst), .bus(bus), .led(led), .err(err), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_mem [DW];
  bit          m_vld [DW];
  logic [31:0] m_rdata = '0;
  logic [31:0] m_eaddr = '0;
  logic [31:0] m_cnt   = '0;
  logic [15:0] m_led   = '0;
  bit          m_err   = 1'b0;
  bit          m_rk    = 1'b1;
  bit          chk_en  = 1'b0;
  bit          cnt_force = 1'b0;
  wire  [31:0] m_cnt_now = cnt_force ? 32'hFFFF_FFFF : m_cnt;

  wire in_ram  = bus.addr < RAMB;
  wire in_mmio = (bus.addr >= MB) && (bus.addr <= MB + 32'd12);
  wire is_bad  = (bus.addr % 4 != 0) || !(in_ram || in_mmio);

  always @(posedge clk) begin
    if (rst) begin
      m_rdata <= '0; m_led <= '0; m_err <= 1'b0; m_eaddr <= '0;
      m_cnt <= '0; m_rk <= 1'b1;
    end else begin
      m_cnt <= m_cnt_now + 32'd1;
      if (bus.data_ram_ena) begin
        if (is_bad) begin
          m_err <= 1'b1;
          if (!m_err) m_eaddr <= bus.addr;
          if (!bus.data_ram_wea) begin m_rdata <= '0; m_rk <= 1'b1; end
        end else if (in_ram) begin
          if (bus.data_ram_wea) begin
            m_mem[bus.addr[11:2]] <= bus.wdata;
            m_vld[bus.addr[11:2]] <= 1'b1;
          end else begin
            m_rdata <= m_mem[bus.addr[11:2]];
            m_rk    <= m_vld[bus.addr[11:2]];
          end
        end else begin
          case (bus.addr - MB)
            32'd0: if (bus.data_ram_wea) m_led <= bus.wdata[15:0];
                   else begin m_rdata <= {16'h0, m_led}; m_rk <= 1'b1; end
            32'd4: if (!bus.data_ram_wea) begin m_rdata <= m_cnt_now; m_rk <= 1'b1; end
            32'd8: if (bus.data_ram_wea) begin m_err <= 1'b0; m_eaddr <= '0; end
                   else begin m_rdata <= {31'h0, m_err}; m_rk <= 1'b1; end
            default: if (!bus.data_ram_wea) begin m_rdata <= '0; m_rk <= 1'b1; end
          endcase
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      if (m_rk) check("model_rdata", bus.rdata, m_rdata);
      check("model_led", {16'h0, led}, {16'h0, m_led});
      check("model_err", {31'h0, err}, {31'h0, m_err});
      check("model_err_addr", err_addr, m_eaddr);
    end
  end

  // ---------------- stimulus ----------------
  // Called just after a negedge; returns at the next negedge with the
  // result of the sampled access visible.
  task automatic acc(input logic e, input logic w, input logic [31:0] a, input logic [31:0] d);
    bus.data_ram_ena = e;
    bus.data_ram_wea = w;
    bus.addr         = a;
    bus.wdata        = d;
    @(negedge clk);
  endtask

  task automatic rd(input logic [31:0] a);  acc(1'b1, 1'b0, a, 32'h0); endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d); acc(1'b1, 1'b1, a, d); endtask

  initial begin
    bus.data_ram_ena = 1'b0; bus.data_ram_wea = 1'b0;
    bus.addr = '0; bus.wdata = '0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    rst    = 1'b0;
    check("reset_rdata", bus.rdata, 32'h0);
    check("reset_led", {16'h0, led}, 32'h0);
    check("reset_err", {31'h0, err}, 32'h0);
    check("reset_err_addr", err_addr, 32'h0);

    // idle then counter read
    repeat (5) acc(1'b0, 1'b0, 32'h0, 32'h0);
    check("idle_rdata", bus.rdata, 32'h0);
    rd(MB + 32'h4);
    check("cnt_after_idle", bus.rdata, 32'd5);

    // RAM write/read, latency and no write-through
    wr(32'h10, 32'hDEAD_BEEF);
    check("no_write_through", bus.rdata, 32'd5);
    rd(32'h10);
    check("ram_rd_0x10", bus.rdata, 32'hDEAD_BEEF);
    wr(32'h0,   32'hA5A5_0000);
    wr(32'hFFC, 32'hCAFE_F00D);
    rd(32'hFFC);
    check("ram_rd_last_word", bus.rdata, 32'hCAFE_F00D);

    // LED
    wr(MB, 32'h1234_ABCD);
    check("led_write", {16'h0, led}, 32'h0000_ABCD);
    rd(MB);
    check("led_read", bus.rdata, 32'h0000_ABCD);

    // CNT is read-only
    wr(MB + 32'h4, 32'h5);
    check("cnt_write_no_err", {31'h0, err}, 32'h0);
    rd(MB + 32'h4);
    check("cnt_after_write", bus.rdata, 32'd14);

    // reserved slot
    wr(MB + 32'hC, 32'h77);
    check("rsvd_write_no_err", {31'h0, err}, 32'h0);
    rd(MB + 32'hC);
    check("rsvd_read", bus.rdata, 32'h0);
    rd(MB);

    // errors
    rd(32'h13);
    check("misal_rdata", bus.rdata, 32'h0);
    check("misal_err", {31'h0, err}, 32'h1);
    check("misal_err_addr", err_addr, 32'h13);
    wr(32'h0004_0000, 32'h99);
    check("unmapped_keep_first", err_addr, 32'h13);
    wr(32'h11, 32'h55);
    wr(MB + 32'h9, 32'h0);
    check("misal_err_reg_no_clear", {31'h0, err}, 32'h1);
    wr(32'h1000, 32'h66);
    wr(MB + 32'h10, 32'h66);
    check("past_mmio_err_addr", err_addr, 32'h13);
    rd(MB + 32'h8);
    check("err_reg_read", bus.rdata, 32'h1);
    rd(32'h0);
    check("ram_word0_intact", bus.rdata, 32'hA5A5_0000);
    rd(32'h10);
    check("ram_0x10_intact", bus.rdata, 32'hDEAD_BEEF);
    check("led_intact", {16'h0, led}, 32'h0000_ABCD);
    wr(MB + 32'h8, 32'h0);
    check("err_clear", {31'h0, err}, 32'h0);
    check("err_addr_clear", err_addr, 32'h0);
    rd(32'h1000);
    check("past_ram_rdata", bus.rdata, 32'h0);
    check("new_first_err", err_addr, 32'h1000);
    wr(MB + 32'h8, 32'h0);

    // reset during a write
    wr(32'h20, 32'h1111_1111);
    rst = 1'b1;
    wr(32'h20, 32'h2222_2222);
    rst = 1'b0;
    check("rst_mid_rdata", bus.rdata, 32'h0);
    check("rst_mid_led", {16'h0, led}, 32'h0);
    rd(32'h20);
    check("rst_write_dropped", bus.rdata, 32'h1111_1111);

    // counter wrap
    force dut.r_cnt = 32'hFFFF_FFFF;
    cnt_force = 1'b1;
    #1 release dut.r_cnt;
    rd(MB + 32'h4);
    cnt_force = 1'b0;
    check("cnt_max", bus.rdata, 32'hFFFF_FFFF);
    rd(MB + 32'h4);
    check("cnt_wrap", bus.rdata, 32'h0);

    acc(1'b0, 1'b0, 32'h0, 32'h0);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
